// File: rtl/bt_pipe_in_sequencer_pkg.sv
// Shared types and widths for the block-throttled input pipe sequencer.
package bt_pipe_in_sequencer_pkg;

    localparam int WORD_W   = 32;
    localparam int BLKCNT_W = 16;

    typedef enum logic [1:0] {
        WAIT_SPACE = 2'd0,
        GRANT      = 2'd1,
        BLOCK      = 2'd2
    } seq_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through sync FIFO; a push into an empty FIFO is visible at the head next cycle.
// Latency 1 cycle; pushes while full and pops while empty are ignored.
module sync_fifo_fwft #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32
) (
    input  logic                     ti_clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Pointers carry one extra bit so equal low bits can be told apart as full vs empty.
    assign level   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (level == (AW+1)'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge ti_clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge ti_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bt_pipe_in_sequencer.sv
// Grants host blocks only when a whole block fits, frames and buffers them, flags protocol errors.
// Latency 1 cycle write-to-dout; ep_ready withholds the next block until FIFO space is reserved.
module bt_pipe_in_sequencer
    import bt_pipe_in_sequencer_pkg::*;
#(
    parameter int BLOCK_WORDS = 256,
    parameter int FIFO_DEPTH  = 1024
) (
    input  logic                          okClk,
    input  logic                          reset,
    input  logic                          ep_write,
    input  logic                          ep_blockstrobe,
    input  logic [WORD_W-1:0]             ep_dataout,
    output logic                          ep_ready,
    output logic [WORD_W-1:0]             dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    input  logic                          err_clear,
    output logic                          err_short,
    output logic                          err_unsolicited,
    output logic [BLKCNT_W-1:0]           blocks_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(BLOCK_WORDS);
    localparam logic [LVL_W-1:0] SPACE_MAX = LVL_W'(FIFO_DEPTH - BLOCK_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(BLOCK_WORDS - 1);

    seq_state_e       state;
    logic [CNT_W-1:0] word_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             in_block;
    logic             push;
    logic             pop;
    logic             last_word;
    logic             short_evt;
    logic             unsol_evt;
    logic [LVL_W-1:0] level_nxt;

    sync_fifo_fwft #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .ti_clk   (okClk),
        .reset    (reset),
        .push     (push),
        .push_dat (ep_dataout),
        .pop      (pop),
        .pop_dat  (dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign dout_valid = !fifo_empty;

    always_comb begin
        in_block  = (state == BLOCK);
        push      = in_block && ep_write && !fifo_full;
        pop       = dout_valid && dout_ready;
        // Occupancy after this edge, so the post-block grant decision sees the final word.
        level_nxt = fifo_level + {{(LVL_W-1){1'b0}}, push} - {{(LVL_W-1){1'b0}}, pop};
        last_word = in_block && ep_write && !ep_blockstrobe && (word_cnt == LAST_IDX);
        short_evt = in_block && ep_blockstrobe;
        unsol_evt = (ep_write && !in_block)
                 || (ep_blockstrobe && (state == WAIT_SPACE))
                 || (in_block && ep_write && fifo_full);
    end

    always_ff @(posedge okClk) begin
        if (reset) begin
            state           <= WAIT_SPACE;
            ep_ready        <= 1'b0;
            word_cnt        <= '0;
            blocks_done     <= '0;
            err_short       <= 1'b0;
            err_unsolicited <= 1'b0;
        end else begin
            // A new error event in the same cycle as err_clear keeps the flag set.
            err_short       <= (err_short && !err_clear) || short_evt;
            err_unsolicited <= (err_unsolicited && !err_clear) || unsol_evt;

            case (state)
                WAIT_SPACE: begin
                    if (fifo_level <= SPACE_MAX) begin
                        state    <= GRANT;
                        ep_ready <= 1'b1;
                    end
                end
                GRANT: begin
                    if (ep_blockstrobe) begin
                        state    <= BLOCK;
                        ep_ready <= 1'b0;
                        word_cnt <= '0;
                    end
                end
                BLOCK: begin
                    if (ep_blockstrobe) begin
                        word_cnt <= '0;
                    end else if (last_word) begin
                        word_cnt    <= '0;
                        blocks_done <= blocks_done + 1'b1;
                        if (level_nxt <= SPACE_MAX) begin
                            state    <= GRANT;
                            ep_ready <= 1'b1;
                        end else begin
                            state    <= WAIT_SPACE;
                            ep_ready <= 1'b0;
                        end
                    end else if (ep_write) begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= WAIT_SPACE;
                    ep_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bt_pipe_in_sequencer.sv
// Directed bench for bt_pipe_in_sequencer: grant timing, framing, buffering and error flags.
module tb_bt_pipe_in_sequencer;

    logic        okClk;
    logic        reset;
    logic        ep_write;
    logic        ep_blockstrobe;
    logic [31:0] ep_dataout;
    logic        ep_ready;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        err_clear;
    logic        err_short;
    logic        err_unsolicited;
    logic [15:0] blocks_done;
    logic [10:0] fifo_level;

    int n_checks = 0;
    int n_errors = 0;
    int bd_exp   = 0;
    bit rand_rdy = 0;

    logic [31:0] exp_q[$];
    logic [31:0] rcv_q[$];

    bt_pipe_in_sequencer #(
        .BLOCK_WORDS (256),
        .FIFO_DEPTH  (1024)
    ) dut (
        .okClk           (okClk),
        .reset           (reset),
        .ep_write        (ep_write),
        .ep_blockstrobe  (ep_blockstrobe),
        .ep_dataout      (ep_dataout),
        .ep_ready        (ep_ready),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .err_clear       (err_clear),
        .err_short       (err_short),
        .err_unsolicited (err_unsolicited),
        .blocks_done     (blocks_done),
        .fifo_level      (fifo_level)
    );

    initial okClk = 1'b0;
    always #5 okClk = ~okClk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    always @(negedge okClk) begin
        if (!reset && dout_valid && dout_ready) begin
            rcv_q.push_back(dout);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge okClk);
        #1;
        if (rand_rdy) dout_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic strobe();
        ep_blockstrobe = 1'b1;
        tick();
        ep_blockstrobe = 1'b0;
    endtask

    task automatic write_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            ep_write   = 1'b1;
            ep_dataout = base + 32'(i);
            exp_q.push_back(base + 32'(i));
            tick();
        end
        ep_write = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 4000 && !ep_ready; i++) tick();
        check(tag, 32'(ep_ready), 32'd1);
    endtask

    task automatic send_block(input string tag, input logic [31:0] base);
        wait_ready(tag);
        strobe();
        write_words(base, 256);
        bd_exp++;
    endtask

    task automatic drain(input string tag);
        rand_rdy   = 0;
        dout_ready = 1'b1;
        for (int i = 0; i < 3000 && fifo_level != 0; i++) tick();
        tick();
        check(tag, 32'(fifo_level), 32'd0);
    endtask

    task automatic compare(input string tag);
        int n;
        int e0;
        check({tag, "_count"}, 32'(rcv_q.size()), 32'(exp_q.size()));
        n  = (rcv_q.size() < exp_q.size()) ? rcv_q.size() : exp_q.size();
        e0 = n_errors;
        for (int i = 0; i < n && n_errors == e0; i++) check({tag, "_data"}, rcv_q[i], exp_q[i]);
        rcv_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ep_ready"}, 32'(ep_ready), 32'd0);
        check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
        check({tag, "_dout"}, dout, 32'd0);
        check({tag, "_err_short"}, 32'(err_short), 32'd0);
        check({tag, "_err_unsol"}, 32'(err_unsolicited), 32'd0);
        check({tag, "_blocks_done"}, 32'(blocks_done), 32'd0);
        check({tag, "_fifo_level"}, 32'(fifo_level), 32'd0);
    endtask

    initial begin
        reset = 1'b1; ep_write = 1'b0; ep_blockstrobe = 1'b0; ep_dataout = '0;
        dout_ready = 1'b0; err_clear = 1'b0;
        repeat (3) tick();
        check_reset_vals("rst");

        // Single block streamed straight through
        reset = 1'b0;
        dout_ready = 1'b1;
        tick();
        check("t1_ready_rise", 32'(ep_ready), 32'd1);
        strobe();
        check("t1_ready_fall", 32'(ep_ready), 32'd0);
        write_words(32'd0, 1);
        check("t1_fwft_valid", 32'(dout_valid), 32'd1);
        check("t1_fwft_dout", dout, 32'd0);
        write_words(32'd1, 9);
        check("t1_ready_low_mid", 32'(ep_ready), 32'd0);
        write_words(32'd10, 246);
        bd_exp++;
        check("t1_ready_after_last", 32'(ep_ready), 32'd1);
        check("t1_blocks_done", 32'(blocks_done), 32'(bd_exp));
        drain("t1_drain");
        compare("t1");

        // Fill FIFO to capacity, then free one block of space
        dout_ready = 1'b0;
        for (int b = 0; b < 4; b++) send_block("t2_ready", 32'h1000 * (b + 1));
        check("t2_level_full", 32'(fifo_level), 32'd1024);
        check("t2_ready_full", 32'(ep_ready), 32'd0);
        repeat (5) tick();
        check("t2_ready_hold", 32'(ep_ready), 32'd0);
        dout_ready = 1'b1;
        repeat (256) tick();
        dout_ready = 1'b0;
        check("t2_level_768", 32'(fifo_level), 32'd768);
        check("t2_ready_not_yet", 32'(ep_ready), 32'd0);
        tick();
        check("t2_ready_reassert", 32'(ep_ready), 32'd1);
        check("t2_blocks_done", 32'(blocks_done), 32'(bd_exp));
        drain("t2_drain");
        compare("t2");

        // Short block followed by a full one
        wait_ready("t3_ready");
        strobe();
        write_words(32'h5000, 100);
        check("t3_no_short_yet", 32'(err_short), 32'd0);
        strobe();
        check("t3_err_short", 32'(err_short), 32'd1);
        write_words(32'h6000, 256);
        bd_exp++;
        check("t3_blocks_done", 32'(blocks_done), 32'(bd_exp));
        drain("t3_drain");
        compare("t3");
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("t3_short_cleared", 32'(err_short), 32'd0);

        // Writes while granted but before any strobe
        wait_ready("t4_ready");
        for (int i = 0; i < 5; i++) begin
            ep_write = 1'b1;
            ep_dataout = 32'hdead0000 + 32'(i);
            tick();
        end
        ep_write = 1'b0;
        check("t4_err_unsol", 32'(err_unsolicited), 32'd1);
        check("t4_level", 32'(fifo_level), 32'd0);
        check("t4_dout_valid", 32'(dout_valid), 32'd0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("t4_unsol_cleared", 32'(err_unsolicited), 32'd0);
        err_clear = 1'b1;
        ep_write  = 1'b1;
        tick();
        err_clear = 1'b0;
        ep_write  = 1'b0;
        check("t4_set_beats_clear", 32'(err_unsolicited), 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        // Reset in mid-block, then recover
        wait_ready("t5_ready");
        strobe();
        write_words(32'h7000, 50);
        reset = 1'b1;
        repeat (2) tick();
        check_reset_vals("t5_rst");
        rcv_q.delete();
        exp_q.delete();
        bd_exp = 0;
        reset = 1'b0;
        ep_blockstrobe = 1'b1;
        tick();
        ep_blockstrobe = 1'b0;
        check("t5_strobe_in_wait", 32'(err_unsolicited), 32'd1);
        check("t5_ready_after_rst", 32'(ep_ready), 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        send_block("t5_ready2", 32'h8000);
        check("t5_blocks_done", 32'(blocks_done), 32'(bd_exp));
        drain("t5_drain");
        compare("t5");
        check("t5_no_short", 32'(err_short), 32'd0);

        // Random consumer backpressure across 8 blocks
        rand_rdy = 1;
        for (int b = 0; b < 8; b++) send_block("t6_ready", 32'h10000 + 32'(b * 256));
        drain("t6_drain");
        check("t6_blocks_done", 32'(blocks_done), 32'(bd_exp));
        compare("t6");
        check("t6_no_unsol", 32'(err_unsolicited), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
